matrix_input_streamer: RTL and testbench

MATRIX_INPUT_STREAMER -- requirements
Module: matrix_input_streamer

---
 rtl/matrix_input_streamer.sv | 117 +++++++++++
 tb/tb_matrix_input_streamer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_input_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_input_streamer
//  Description : Buffers an N x N pair of matrices (A, B) row by row, then
//                streams A by columns and B by rows as one N-beat burst.
//  Revision    : 1.0  initial release
// ============================================================================
module matrix_input_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             load_valid,
    output logic                             load_ready,
    input  logic [N-1:0][DATA_WIDTH-1:0]     load_a_row,
    input  logic [N-1:0][DATA_WIDTH-1:0]     load_b_row,
    input  logic                             array_ready,
    output logic                             input_valid,
    output logic [N-1:0][DATA_WIDTH-1:0]     a_data,
    output logic [N-1:0][DATA_WIDTH-1:0]     b_data,
    output logic                             busy
);

    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        FULL   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t                        state;
    state_t                        state_next;
    logic [CW-1:0]                 rc;
    logic [CW-1:0]                 k;
    logic [N-1:0][DATA_WIDTH-1:0]  a_buf [N];
    logic [N-1:0][DATA_WIDTH-1:0]  b_buf [N];
    logic                          load_fire;

    assign load_fire = load_valid & load_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        load_ready  = 1'b0;
        input_valid = 1'b0;
        busy        = 1'b0;
        case (state)
            LOAD: begin
                load_ready = 1'b1;
                if (load_valid && (rc == LAST)) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                busy = 1'b1;
                if (array_ready) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                busy        = 1'b1;
                input_valid = 1'b1;
                // The burst is never interrupted; only the final beat leaves STREAM.
                if (k == LAST) begin
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rc <= '0;
            k  <= '0;
            for (int i = 0; i < N; i++) begin
                a_buf[i] <= '0;
                b_buf[i] <= '0;
            end
        end else begin
            if (load_fire) begin
                a_buf[rc] <= load_a_row;
                b_buf[rc] <= load_b_row;
                rc        <= (rc == LAST) ? '0 : rc + CW'(1);
            end
            if (input_valid) begin
                k <= (k == LAST) ? '0 : k + CW'(1);
            end
        end
    end

    // Beat k presents column k of A and row k of B; outputs are zero between beats.
    always_comb begin
        a_data = '0;
        b_data = '0;
        if (input_valid) begin
            b_data = b_buf[k];
            for (int i = 0; i < N; i++) begin
                a_data[i] = a_buf[i][k];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_input_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_input_streamer
//  Description : Self-checking bench for matrix_input_streamer against a
//                matrix-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_matrix_input_streamer;

    localparam int DW = 8;
    localparam int N  = 4;

    typedef logic [N-1:0][DW-1:0] vec_t;

    logic clk;
    logic reset;
    logic load_valid;
    logic load_ready;
    vec_t load_a_row;
    vec_t load_b_row;
    logic array_ready;
    logic input_valid;
    vec_t a_data;
    vec_t b_data;
    logic busy;

    int errors;
    int checks;
    int ma [N][N];
    int mb [N][N];

    matrix_input_streamer #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_a_row  (load_a_row),
        .load_b_row  (load_b_row),
        .array_ready (array_ready),
        .input_valid (input_valid),
        .a_data      (a_data),
        .b_data      (b_data),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Column kk of A: element i is A[i][kk].
    function automatic vec_t col_a(int kk);
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = DW'(ma[i][kk]);
        return v;
    endfunction

    function automatic vec_t row_a(int r);
        vec_t v;
        for (int j = 0; j < N; j++) v[j] = DW'(ma[r][j]);
        return v;
    endfunction

    function automatic vec_t row_b(int r);
        vec_t v;
        for (int j = 0; j < N; j++) v[j] = DW'(mb[r][j]);
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int j = 0; j < N; j++) v[j] = DW'($urandom_range(0, 255));
        return v;
    endfunction

    function automatic void rand_matrix();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = $urandom_range(0, 255);
                mb[i][j] = $urandom_range(0, 255);
            end
    endfunction

    // Presents all N rows on consecutive cycles; leaves load_valid low.
    task automatic load_all();
        for (int r = 0; r < N; r++) begin
            load_valid = 1'b1;
            load_a_row = row_a(r);
            load_b_row = row_b(r);
            tick();
        end
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready: got %b want 1", load_ready); end
        checks++; if (input_valid !== 1'b0) begin errors++; $display("FAIL reset_input_valid: got %b want 0", input_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (a_data !== '0) begin errors++; $display("FAIL reset_a_data: got %h want 0", a_data); end
        checks++; if (b_data !== '0) begin errors++; $display("FAIL reset_b_data: got %h want 0", b_data); end
    endtask

    task automatic test_back_to_back();
        vec_t ea, eb;
        logic exp_r, exp_v;
        vec_t a0, b0, a3, b3;
        a0 = {8'd13, 8'd9, 8'd5, 8'd1};
        b0 = {8'd19, 8'd18, 8'd17, 8'd16};
        a3 = {8'd16, 8'd12, 8'd8, 8'd4};
        b3 = {8'd31, 8'd30, 8'd29, 8'd28};
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = 4 * i + j + 1;
                mb[i][j] = 16 + 4 * i + j;
            end
        array_ready = 1'b1;
        for (int t = 1; t <= 11; t++) begin
            load_valid = (t <= N);
            load_a_row = (t <= N) ? row_a(t - 1) : rand_vec();
            load_b_row = (t <= N) ? row_b(t - 1) : rand_vec();
            exp_r = !(t >= 5 && t <= 9);
            exp_v = (t >= 6 && t <= 9);
            ea = exp_v ? col_a(t - 6) : '0;
            eb = exp_v ? row_b(t - 6) : '0;
            checks++; if (load_ready !== exp_r) begin errors++; $display("FAIL b2b_load_ready cycle %0d: got %b want %b", t, load_ready, exp_r); end
            checks++; if (input_valid !== exp_v) begin errors++; $display("FAIL b2b_input_valid cycle %0d: got %b want %b", t, input_valid, exp_v); end
            checks++; if (busy !== !exp_r) begin errors++; $display("FAIL b2b_busy cycle %0d: got %b want %b", t, busy, !exp_r); end
            checks++; if (a_data !== ea) begin errors++; $display("FAIL b2b_a_data cycle %0d: got %h want %h", t, a_data, ea); end
            checks++; if (b_data !== eb) begin errors++; $display("FAIL b2b_b_data cycle %0d: got %h want %h", t, b_data, eb); end
            if (t == 6) begin
                checks++; if (a_data !== a0 || b_data !== b0) begin errors++; $display("FAIL b2b_beat0_literal: got a=%h b=%h want a=%h b=%h", a_data, b_data, a0, b0); end
            end
            if (t == 9) begin
                checks++; if (a_data !== a3 || b_data !== b3) begin errors++; $display("FAIL b2b_beat3_literal: got a=%h b=%h want a=%h b=%h", a_data, b_data, a3, b3); end
            end
            tick();
        end
        load_valid = 1'b0;
    endtask

    task automatic test_gapped_load();
        int pat [6] = '{1, 0, 1, 0, 1, 1};
        int r;
        r = 0;
        rand_matrix();
        array_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            load_valid = pat[c][0];
            load_a_row = (pat[c] != 0) ? row_a(r) : rand_vec();
            load_b_row = (pat[c] != 0) ? row_b(r) : rand_vec();
            checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL gap_load_ready cycle %0d: got %b want 1", c, load_ready); end
            tick();
            if (pat[c] != 0) r++;
        end
        load_valid = 1'b0;
        checks++; if (load_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL gap_full_entry: got ready=%b busy=%b want ready=0 busy=1", load_ready, busy); end
    endtask

    task automatic test_stall();
        for (int c = 0; c < 10; c++) begin
            array_ready = 1'b0;
            checks++; if (input_valid !== 1'b0 || busy !== 1'b1 || load_ready !== 1'b0) begin errors++; $display("FAIL stall_hold cycle %0d: got valid=%b busy=%b ready=%b want 0 1 0", c, input_valid, busy, load_ready); end
            tick();
        end
        array_ready = 1'b1;
        checks++; if (input_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got valid=%b want 0", input_valid); end
        tick();
        for (int k = 0; k < N; k++) begin
            checks++; if (input_valid !== 1'b1) begin errors++; $display("FAIL stall_beat_valid %0d: got %b want 1", k, input_valid); end
            checks++; if (a_data !== col_a(k) || b_data !== row_b(k)) begin errors++; $display("FAIL stall_beat_data %0d: got a=%h b=%h want a=%h b=%h", k, a_data, b_data, col_a(k), row_b(k)); end
            tick();
        end
        checks++; if (load_ready !== 1'b1 || input_valid !== 1'b0 || a_data !== '0) begin errors++; $display("FAIL stall_end: got ready=%b valid=%b a=%h want 1 0 0", load_ready, input_valid, a_data); end
    endtask

    task automatic test_drop_ready();
        rand_matrix();
        array_ready = 1'b1;
        load_all();
        checks++; if (load_ready !== 1'b0 || input_valid !== 1'b0) begin errors++; $display("FAIL drop_full: got ready=%b valid=%b want 0 0", load_ready, input_valid); end
        tick();
        for (int k = 0; k < N; k++) begin
            if (k >= 1) array_ready = 1'b0;
            checks++; if (input_valid !== 1'b1) begin errors++; $display("FAIL drop_beat_valid %0d: got %b want 1", k, input_valid); end
            checks++; if (a_data !== col_a(k) || b_data !== row_b(k)) begin errors++; $display("FAIL drop_beat_data %0d: got a=%h b=%h want a=%h b=%h", k, a_data, b_data, col_a(k), row_b(k)); end
            tick();
        end
        checks++; if (load_ready !== 1'b1 || input_valid !== 1'b0) begin errors++; $display("FAIL drop_end: got ready=%b valid=%b want 1 0", load_ready, input_valid); end
    endtask

    task automatic test_load_during_stream();
        rand_matrix();
        array_ready = 1'b0;
        load_all();
        for (int c = 0; c < 3; c++) begin
            load_valid  = 1'b1;
            load_a_row  = rand_vec();
            load_b_row  = rand_vec();
            array_ready = (c == 2);
            checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL lds_full_ready cycle %0d: got %b want 0", c, load_ready); end
            tick();
        end
        for (int k = 0; k < N; k++) begin
            load_a_row = rand_vec();
            load_b_row = rand_vec();
            if (k == N - 1) load_valid = 1'b0;
            checks++; if (input_valid !== 1'b1 || load_ready !== 1'b0) begin errors++; $display("FAIL lds_beat_ctrl %0d: got valid=%b ready=%b want 1 0", k, input_valid, load_ready); end
            checks++; if (a_data !== col_a(k) || b_data !== row_b(k)) begin errors++; $display("FAIL lds_beat_data %0d: got a=%h b=%h want a=%h b=%h", k, a_data, b_data, col_a(k), row_b(k)); end
            tick();
        end
        checks++; if (load_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL lds_end: got ready=%b busy=%b want 1 0", load_ready, busy); end
    endtask

    task automatic test_reset_mid_burst();
        rand_matrix();
        array_ready = 1'b1;
        load_all();
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++; if (input_valid !== 1'b1 || a_data !== col_a(k)) begin errors++; $display("FAIL rmb_beat %0d: got valid=%b a=%h want 1 %h", k, input_valid, a_data, col_a(k)); end
            if (k == 2) reset = 1'b1;
            tick();
        end
        reset = 1'b0;
        checks++; if (input_valid !== 1'b0 || a_data !== '0 || b_data !== '0 || load_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rmb_after_reset: got valid=%b a=%h b=%h ready=%b busy=%b want 0 0 0 1 0", input_valid, a_data, b_data, load_ready, busy); end
        tick();
        checks++; if (input_valid !== 1'b0) begin errors++; $display("FAIL rmb_no_more_beats: got valid=%b want 0", input_valid); end
        rand_matrix();
        load_all();
        checks++; if (load_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rmb_reload_full: got ready=%b busy=%b want 0 1", load_ready, busy); end
        tick();
        for (int k = 0; k < N; k++) begin
            checks++; if (input_valid !== 1'b1 || a_data !== col_a(k) || b_data !== row_b(k)) begin errors++; $display("FAIL rmb_reload_beat %0d: got valid=%b a=%h b=%h want 1 %h %h", k, input_valid, a_data, b_data, col_a(k), row_b(k)); end
            tick();
        end
        checks++; if (input_valid !== 1'b0 || load_ready !== 1'b1) begin errors++; $display("FAIL rmb_reload_end: got valid=%b ready=%b want 0 1", input_valid, load_ready); end
    endtask

    task automatic test_random();
        int gap;
        int stall;
        for (int it = 0; it < 8; it++) begin
            rand_matrix();
            array_ready = 1'b0;
            for (int r = 0; r < N; r++) begin
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    load_valid = 1'b0;
                    load_a_row = rand_vec();
                    load_b_row = rand_vec();
                    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rnd_idle_ready it %0d: got %b want 1", it, load_ready); end
                    tick();
                end
                load_valid = 1'b1;
                load_a_row = row_a(r);
                load_b_row = row_b(r);
                checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rnd_load_ready it %0d row %0d: got %b want 1", it, r, load_ready); end
                tick();
            end
            load_valid = 1'b0;
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                checks++; if (input_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rnd_stall it %0d: got valid=%b busy=%b want 0 1", it, input_valid, busy); end
                tick();
            end
            array_ready = 1'b1;
            checks++; if (input_valid !== 1'b0 || load_ready !== 1'b0) begin errors++; $display("FAIL rnd_full it %0d: got valid=%b ready=%b want 0 0", it, input_valid, load_ready); end
            tick();
            for (int k = 0; k < N; k++) begin
                array_ready = $urandom_range(0, 1);
                checks++; if (input_valid !== 1'b1 || a_data !== col_a(k) || b_data !== row_b(k)) begin errors++; $display("FAIL rnd_beat it %0d k %0d: got valid=%b a=%h b=%h want 1 %h %h", it, k, input_valid, a_data, b_data, col_a(k), row_b(k)); end
                tick();
            end
            checks++; if (load_ready !== 1'b1 || input_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rnd_end it %0d: got ready=%b valid=%b busy=%b want 1 0 0", it, load_ready, input_valid, busy); end
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        reset       = 1'b1;
        load_valid  = 1'b0;
        array_ready = 1'b0;
        load_a_row  = '0;
        load_b_row  = '0;
        test_reset();
        test_back_to_back();
        test_gapped_load();
        test_stall();
        test_drop_ready();
        test_load_during_stream();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
